// File: rtl/alu_pipe.sv
// alu_pipe: clocked N-bit ALU behind valid/ready handshakes on both sides.
// Single-cycle ops register their result on the accept edge; MUL (shift-add)
// and DIV (restoring) iterate once per cycle for N cycles before presenting.
module alu_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic [N-1:0] Y_hi,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         div_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  N_VAL    = N'(N);
  localparam logic [N-1:0]  ONE      = N'(1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_DEC = 4'd2;
  localparam logic [3:0] OP_INC = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic            is_mul_reg;
  logic [N-1:0]    opnd_reg;     // multiplicand (MUL) or divisor (DIV)
  logic [N-1:0]    hi_reg;       // product high word / partial remainder
  logic [N-1:0]    lo_reg;       // multiplier shifting out / quotient shifting in
  logic [N-1:0]    y_reg;
  logic [N-1:0]    y_hi_reg;
  logic            carry_reg;
  logic            overflow_reg;
  logic            zero_reg;
  logic            negative_reg;
  logic            div_zero_reg;

  logic            accept;
  logic            is_iter;

  // Single-cycle datapath, evaluated on the live operands at accept time
  logic [N:0]      add_sum;
  logic [N:0]      sub_diff;
  logic [N-1:0]    inc_val;
  logic [N-1:0]    dec_val;
  logic [N-1:0]    sra_val;
  logic            shift_big;
  logic [N-1:0]    sc_y;
  logic [N-1:0]    sc_hi;
  logic            sc_c;
  logic            sc_v;
  logic            sc_z;
  logic            sc_n;
  logic            sc_dz;

  // One iteration of the multiply / divide units
  logic [N:0]      mul_sum;
  logic [N-1:0]    mul_hi_next;
  logic [N-1:0]    mul_lo_next;
  logic [N:0]      div_win;
  logic            div_ok;
  logic [N-1:0]    div_sub;
  logic [N-1:0]    div_hi_next;
  logic [N-1:0]    div_lo_next;
  logic [N-1:0]    iter_hi;
  logic [N-1:0]    iter_lo;

  assign in_ready  = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (opcode == OP_MUL) || ((opcode == OP_DIV) && (B != '0));

  assign Y        = y_reg;
  assign Y_hi     = y_hi_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;
  assign negative = negative_reg;
  assign div_zero = div_zero_reg;

  assign add_sum   = {1'b0, A} + {1'b0, B};
  assign sub_diff  = {1'b0, A} - {1'b0, B};
  assign inc_val   = A + ONE;
  assign dec_val   = A - ONE;
  assign sra_val   = $signed(A) >>> B;
  assign shift_big = (B >= N_VAL);

  // Shift-add: conditionally add the multiplicand into the high word, then
  // shift the whole {carry, hi, lo} right by one.
  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_hi_next = mul_sum[N:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[N-1:1]};

  // Restoring division: bring the next dividend bit into the remainder and
  // subtract the divisor when it fits. The remainder stays below the divisor,
  // so the N-bit difference is exact whenever the subtraction is taken.
  assign div_win     = {hi_reg, lo_reg[N-1]};
  assign div_ok      = (div_win >= {1'b0, opnd_reg});
  assign div_sub     = div_win[N-1:0] - opnd_reg;
  assign div_hi_next = div_ok ? div_sub : div_win[N-1:0];
  assign div_lo_next = {lo_reg[N-2:0], div_ok};

  assign iter_hi = is_mul_reg ? mul_hi_next : div_hi_next;
  assign iter_lo = is_mul_reg ? mul_lo_next : div_lo_next;

  // Result and flags for every op that completes on the accept edge
  always_comb begin
    sc_y  = '0;
    sc_hi = '0;
    sc_c  = 1'b0;
    sc_v  = 1'b0;
    sc_dz = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_y = add_sum[N-1:0];
        sc_c = add_sum[N];
        sc_v = (A[N-1] == B[N-1]) && (add_sum[N-1] != A[N-1]);
      end
      OP_SUB: begin
        sc_y = sub_diff[N-1:0];
        sc_c = sub_diff[N];
        sc_v = (A[N-1] != B[N-1]) && (sub_diff[N-1] != A[N-1]);
      end
      OP_DEC: begin
        sc_y = dec_val;
        sc_c = (A == '0);
        sc_v = A[N-1] && !dec_val[N-1];
      end
      OP_INC: begin
        sc_y = inc_val;
        sc_c = (A == '1);
        sc_v = !A[N-1] && inc_val[N-1];
      end
      OP_NOT: sc_y = ~A;
      OP_AND: sc_y = A & B;
      OP_OR:  sc_y = A | B;
      OP_XOR: sc_y = A ^ B;
      OP_DIV: begin
        // Only reached here with a zero divisor
        sc_y  = '1;
        sc_hi = A;
        sc_dz = 1'b1;
      end
      OP_SHL: sc_y = shift_big ? '0 : (A << B);
      OP_SHR: sc_y = shift_big ? '0 : (A >> B);
      OP_SRA: sc_y = shift_big ? {N{A[N-1]}} : sra_val;
      default: sc_y = '0;
    endcase
    // Divide-by-zero reports only div_zero; everything else derives from Y
    sc_z = (sc_y == '0) && !sc_dz;
    sc_n = sc_y[N-1] && !sc_dz;
  end

  // Control FSM plus operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      is_mul_reg   <= 1'b0;
      opnd_reg     <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      y_reg        <= '0;
      y_hi_reg     <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      negative_reg <= 1'b0;
      div_zero_reg <= 1'b0;
    end else if (accept) begin
      // Same handling from IDLE and from a back-to-back accept in DONE
      if (is_iter) begin
        state_reg  <= CALC;
        count_reg  <= '0;
        is_mul_reg <= (opcode == OP_MUL);
        opnd_reg   <= (opcode == OP_MUL) ? A : B;
        hi_reg     <= '0;
        lo_reg     <= (opcode == OP_MUL) ? B : A;
      end else begin
        state_reg    <= DONE;
        y_reg        <= sc_y;
        y_hi_reg     <= sc_hi;
        carry_reg    <= sc_c;
        overflow_reg <= sc_v;
        zero_reg     <= sc_z;
        negative_reg <= sc_n;
        div_zero_reg <= sc_dz;
      end
    end else begin
      case (state_reg)
        CALC: begin
          hi_reg    <= iter_hi;
          lo_reg    <= iter_lo;
          count_reg <= count_reg + CNT_ONE;
          if (count_reg == CNT_LAST) begin
            state_reg    <= DONE;
            y_reg        <= iter_lo;
            y_hi_reg     <= iter_hi;
            carry_reg    <= 1'b0;
            overflow_reg <= is_mul_reg && (iter_hi != '0);
            zero_reg     <= is_mul_reg ? ({iter_hi, iter_lo} == '0) : (iter_lo == '0);
            negative_reg <= iter_lo[N-1];
            div_zero_reg <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        IDLE: ;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe (N=8). The driver pushes the
// hand-computed response into a queue on accept; a monitor on the falling
// edge pops and compares every result the DUT hands over.
module tb_alu_pipe;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] hi;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    logic       dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Y;
  logic [N-1:0] Y_hi;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         div_zero;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  alu_pipe #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Y_hi(Y_hi),
    .carry(carry), .overflow(overflow), .zero(zero),
    .negative(negative), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every handed-over result must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t got;
      exp_t want;
      got = '{y: Y, hi: Y_hi, c: carry, v: overflow, z: zero, n: negative, dz: div_zero};
      total++;
      txn++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result#%0d unexpected: got y=%h hi=%h cvznd=%b%b%b%b%b want none",
                 txn, got.y, got.hi, got.c, got.v, got.z, got.n, got.dz);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL result#%0d: got y=%h hi=%h cvznd=%b%b%b%b%b want y=%h hi=%h cvznd=%b%b%b%b%b",
                   txn, got.y, got.hi, got.c, got.v, got.z, got.n, got.dz,
                   want.y, want.hi, want.c, want.v, want.z, want.n, want.dz);
        end else begin
          $display("result#%0d y=%h hi=%h cvznd=%b%b%b%b%b ok", txn, got.y, got.hi,
                   got.c, got.v, got.z, got.n, got.dz);
        end
      end
    end
  end

  // Issue one op, push its expectation at accept, and check accept-to-valid latency
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input exp_t e, input int lat_want);
    int t;
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = op; A = a; B = b;
    #1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout op=%0d: in_ready=0 want 1", op);
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Scramble operands after accept; the captured copy must be used
    in_valid = 1'b0; opcode = 4'hF; A = 8'hA5; B = 8'h5A;
    lat = 1;
    while (!out_valid && lat < 50) begin
      chk("in_ready_calc", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency_op%0d", op), lat, lat_want);
  endtask

  function automatic exp_t mk(input logic [7:0] y, input logic [7:0] hi,
                              input logic c, input logic v, input logic z,
                              input logic n, input logic dz);
    mk = '{y: y, hi: hi, c: c, v: v, z: z, n: n, dz: dz};
  endfunction

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; opcode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_outputs", {16'd0, Y, Y_hi}, 32'd0);
    chk("reset_flags", {27'd0, carry, overflow, zero, negative, div_zero}, 32'd0);
    rst = 1'b0;

    //       op     A      B                 y      hi     c     v     z     n     dz   lat
    send(4'd0,  8'h7F, 8'h01, mk(8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1);
    send(4'd1,  8'h00, 8'h01, mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    send(4'd3,  8'hFF, 8'h00, mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    send(4'd2,  8'h80, 8'h00, mk(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1);
    send(4'd2,  8'h00, 8'h00, mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    send(4'd0,  8'hFF, 8'h01, mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    send(4'd1,  8'h80, 8'h01, mk(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1);
    send(4'd4,  8'h5A, 8'h00, mk(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    send(4'd6,  8'h50, 8'h05, mk(8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    send(4'd8,  8'hFF, 8'hFF, mk(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 9);
    send(4'd8,  8'h0C, 8'h0B, mk(8'h84, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 9);
    send(4'd8,  8'h00, 8'h37, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 9);
    send(4'd9,  8'd100, 8'd7, mk(8'd14,  8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 9);
    send(4'd9,  8'd5,  8'd0,  mk(8'hFF, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1);
    send(4'd9,  8'd3,  8'd10, mk(8'h00, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 9);
    send(4'd9,  8'hFF, 8'h01, mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 9);
    send(4'd12, 8'h80, 8'd3,  mk(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    send(4'd10, 8'h01, 8'd9,  mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    send(4'd11, 8'h80, 8'd7,  mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    send(4'd12, 8'h80, 8'd200, mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    send(4'd10, 8'h81, 8'd7,  mk(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    send(4'd14, 8'h12, 8'h34, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);

    // Backpressure: result must hold while the consumer stalls
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'd5, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    repeat (3) begin
      @(posedge clk); #2;
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_y", {24'd0, Y}, 32'h30);
      chk("stall_flags", {27'd0, carry, overflow, zero, negative, div_zero}, 32'd0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    // Release and issue in the same cycle: back-to-back accept
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; opcode = 4'd7; A = 8'hF0; B = 8'h0F;
    exp_q.push_back(mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = 4'hF; A = 8'h00; B = 8'h00;
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_y", {24'd0, Y}, 32'hFF);

    // Reset in the 4th CALC cycle of a MUL aborts it for good
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 4'd8; A = 8'h11; B = 8'h22;
    @(posedge clk); #1;          // accept edge
    in_valid = 1'b0;
    repeat (3) @(posedge clk);   // three iterations done, now in 4th CALC cycle
    #1;
    chk("calc_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_idle_in_ready", {31'd0, in_ready}, 32'd1);
    t = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) t++;
    end
    chk("abort_no_result", t, 0);

    // Drain: every pushed expectation must have been consumed
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
